bp_cce_inst_fetch: RTL and testbench
====================================

Name: bp_cce_inst_fetch

Overview:
- Upstream instruction-fetch stage of the microcoded CCE.
- Holds the CCE instruction RAM and the PC register. Presents one instruction per cycle (fetch_pc_o, instruction_v_o, instruction_o) to the decode stage and the instruction tracer.
- Microcode is loaded and read back over a config-bus port while in load mode.
- Sequential PC advance, stalls and branch redirects are applied with zero fetch bubbles.

Parameters:
- inst_width_p, 48, width of one bp_cce_inst_s instruction
- pc_width_p, 8, width of the PC / RAM address
- num_inst_p, 256, number of RAM entries (must be ≤ 2^pc_width_p and ≥ 2)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- mode_i  in  1  0 = load (config access), 1 = run (fetch)
- cfg_w_v_i  in  1  config write strobe
- cfg_r_v_i  in  1  config read strobe
- cfg_addr_i  in  pc_width_p  config RAM address
- cfg_data_i  in  inst_width_p  config write data
- cfg_r_v_o  out  1  config read data valid
- cfg_r_data_o  out  inst_width_p  config read data
- stall_i  in  1  decode cannot accept; hold current instruction
- redirect_v_i  in  1  branch/jump taken
- redirect_pc_i  in  pc_width_p  redirect target
- fetch_pc_o  out  pc_width_p  PC of instruction_o
- instruction_v_o  out  1  instruction_o valid
- instruction_o  out  inst_width_p  fetched instruction
- err_o  out  1  sticky error

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk_i.
  - While reset_n_i is 0, every output is 0 and state is LOAD.
  - RAM contents are not cleared.
  - Reset asserted mid-run drops any in-flight fetch.
- RAM: single-port, synchronous read, 1-cycle latency.
- Port-sharing priority: fetch when state ≠ LOAD; otherwise cfg write over cfg read.
- FSM states: LOAD, BOOT, RUN.
  - LOAD → BOOT when mode_i = 1. BOOT → RUN unconditionally. RUN/BOOT → LOAD when mode_i = 0.
  - Leaving RUN: instruction_v_o is 0 from the next cycle.
- LOAD:
  - cfg_w_v_i writes cfg_data_i to RAM[cfg_addr_i].
  - cfg_r_v_i alone reads RAM[cfg_addr_i]; cfg_r_v_o = 1 and cfg_r_data_o is valid exactly one cycle later, 0 otherwise.
  - Simultaneous cfg_w_v_i and cfg_r_v_i: the write is performed, the read is dropped, and err_o is set.
  - cfg_addr_i ≥ num_inst_p: the access is dropped and err_o is set.
  - instruction_v_o = 0.
- BOOT:
  - RAM read issued at address 0; fetch_pc register loaded with 0.
  - instruction_v_o = 0.
  - stall_i and redirect_v_i are ignored.
- RUN:
  - instruction_v_o = 1 every cycle; instruction_o = RAM[fetch_pc_o].
  - Each cycle next_pc is computed, RAM is read at next_pc, and fetch_pc_o <= next_pc at the edge.
  - next_pc priority:
    1. redirect_v_i → redirect_pc_i
    2. stall_i → fetch_pc_o
    3. otherwise sequential → fetch_pc_o+1, wrapping to 0 after num_inst_p-1
  - Redirect and stall in the same cycle: the redirect wins. The instruction on the outputs that cycle is considered squashed by decode.
  - Redirect target ≥ num_inst_p: next_pc = 0 and err_o is set.
  - Stalls hold fetch_pc_o and instruction_o stable indefinitely (same address re-read).
  - Any cfg_w_v_i or cfg_r_v_i in RUN is ignored; a write also sets err_o.
- err_o: sticky; cleared only by reset.
- Gating: instruction_o and cfg_r_data_o are forced to 0 whenever their valid is 0.
- Latency: instruction at a redirect target appears on the cycle immediately after redirect_v_i; no bubble.

Test Plan:
1. Load and read back: load RAM[0..3] = 0x11,0x22,0x33,0x44. Read addr 2 → cfg_r_v_o = 1 one cycle later with data 0x33; err_o = 0.
2. Boot and sequential fetch: set mode_i = 1 after loading.
   - instruction_v_o is 0 for the cycle mode_i is first sampled and for the BOOT cycle; instruction_v_o = 1 from the cycle after BOOT.
   - Then pc/instruction = 0/0x11, 1/0x22, 2/0x33 on consecutive cycles.
3. Stall: stall_i held 3 cycles at pc 1 → pc 1 / 0x22 held 3 cycles, then pc 2 / 0x33.
4. Redirect over stall: at pc 2, redirect_v_i = 1 with target 0 and stall_i = 1 → next cycle pc 0 / 0x11.
   - A redirect to 0x1FF with num_inst_p = 256 and pc_width_p = 9 → pc 0 and err_o = 1.
5. Wrap: run from pc 254 with num_inst_p = 256 → pc sequence 254, 255, 0.
6. Illegal access and reset:
   - cfg_w_v_i in RUN → RAM unchanged, err_o = 1.
   - reset_n_i = 0 mid-RUN → all outputs 0 next cycle, state LOAD, RAM contents retained (verified by readback).

Source files
------------

// File: rtl/bp_cce_inst_fetch_if.sv
// Signal bundle between the CCE instruction-fetch stage and its driver:
// mode select, config bus, fetch control, fetched instruction and sticky error.
interface bp_cce_inst_fetch_if #(
  parameter int inst_width_p = 48,
  parameter int pc_width_p   = 8
);
  logic                    mode_i;
  logic                    cfg_w_v_i;
  logic                    cfg_r_v_i;
  logic [pc_width_p-1:0]   cfg_addr_i;
  logic [inst_width_p-1:0] cfg_data_i;
  logic                    cfg_r_v_o;
  logic [inst_width_p-1:0] cfg_r_data_o;
  logic                    stall_i;
  logic                    redirect_v_i;
  logic [pc_width_p-1:0]   redirect_pc_i;
  logic [pc_width_p-1:0]   fetch_pc_o;
  logic                    instruction_v_o;
  logic [inst_width_p-1:0] instruction_o;
  logic                    err_o;

  modport master (
    output mode_i, cfg_w_v_i, cfg_r_v_i, cfg_addr_i, cfg_data_i,
           stall_i, redirect_v_i, redirect_pc_i,
    input  cfg_r_v_o, cfg_r_data_o, fetch_pc_o, instruction_v_o,
           instruction_o, err_o
  );

  modport slave (
    input  mode_i, cfg_w_v_i, cfg_r_v_i, cfg_addr_i, cfg_data_i,
           stall_i, redirect_v_i, redirect_pc_i,
    output cfg_r_v_o, cfg_r_data_o, fetch_pc_o, instruction_v_o,
           instruction_o, err_o
  );
endinterface

// File: rtl/bp_cce_inst_fetch.sv
// CCE instruction fetch: microcode RAM shared between config access (LOAD)
// and a zero-bubble fetch pipeline (BOOT/RUN) with stall and redirect.
module bp_cce_inst_fetch #(
  parameter int inst_width_p = 48,
  parameter int pc_width_p   = 8,
  parameter int num_inst_p   = 256
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  bp_cce_inst_fetch_if.slave  io
);

  localparam int addr_w_lp = (num_inst_p > 1) ? $clog2(num_inst_p) : 1;
  localparam logic [pc_width_p-1:0] last_pc_lp = pc_width_p'(num_inst_p - 1);

  typedef enum logic [1:0] {
    e_load = 2'd0,
    e_boot = 2'd1,
    e_run  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [pc_width_p-1:0]   fetch_pc_q, fetch_pc_d;
  logic                    cfg_r_v_q, cfg_r_v_d;
  logic                    err_q, err_d;
  logic                    ram_we_s, ram_re_s;
  logic [pc_width_p-1:0]   ram_addr_s;
  logic [inst_width_p-1:0] ram_rdata_q;
  logic [inst_width_p-1:0] mem_q [num_inst_p];

  function automatic logic addr_ok(input logic [pc_width_p-1:0] addr);
    return (32'(addr) < 32'(num_inst_p));
  endfunction

  // Next-state, next-PC and RAM port arbitration
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    cfg_r_v_d  = 1'b0;
    err_d      = err_q;
    ram_we_s   = 1'b0;
    ram_re_s   = 1'b0;
    ram_addr_s = io.cfg_addr_i;
    case (state_q)
      e_load: begin
        state_d   = io.mode_i ? e_boot : e_load;
        // A write always beats a read; out-of-range addresses are dropped
        ram_we_s  = reset_n_i & io.cfg_w_v_i & addr_ok(io.cfg_addr_i);
        ram_re_s  = io.cfg_r_v_i & ~io.cfg_w_v_i & addr_ok(io.cfg_addr_i);
        cfg_r_v_d = ram_re_s;
        err_d     = err_q
                  | (io.cfg_w_v_i & io.cfg_r_v_i)
                  | ((io.cfg_w_v_i | io.cfg_r_v_i) & ~addr_ok(io.cfg_addr_i));
      end
      e_boot: begin
        state_d    = io.mode_i ? e_run : e_load;
        ram_re_s   = 1'b1;
        ram_addr_s = '0;
        fetch_pc_d = '0;
      end
      e_run: begin
        state_d  = io.mode_i ? e_run : e_load;
        ram_re_s = 1'b1;
        if (io.redirect_v_i) begin
          fetch_pc_d = addr_ok(io.redirect_pc_i) ? io.redirect_pc_i : '0;
        end else if (io.stall_i) begin
          fetch_pc_d = fetch_pc_q;
        end else if (fetch_pc_q == last_pc_lp) begin
          fetch_pc_d = '0;
        end else begin
          fetch_pc_d = fetch_pc_q + {{(pc_width_p-1){1'b0}}, 1'b1};
        end
        ram_addr_s = fetch_pc_d;
        err_d      = err_q | io.cfg_w_v_i
                   | (io.redirect_v_i & ~addr_ok(io.redirect_pc_i));
      end
      default: begin
        state_d = e_load;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= e_load;
      fetch_pc_q <= '0;
      cfg_r_v_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cfg_r_v_q  <= cfg_r_v_d;
      err_q      <= err_d;
    end
  end

  // Single-port instruction RAM, contents survive reset
  always_ff @(posedge clk_i) begin
    if (ram_we_s) begin
      mem_q[ram_addr_s[addr_w_lp-1:0]] <= io.cfg_data_i;
    end
    if (ram_re_s) begin
      ram_rdata_q <= mem_q[ram_addr_s[addr_w_lp-1:0]];
    end
  end

  assign io.fetch_pc_o      = fetch_pc_q;
  assign io.instruction_v_o = (state_q == e_run);
  assign io.instruction_o   = (state_q == e_run) ? ram_rdata_q : '0;
  assign io.cfg_r_v_o       = cfg_r_v_q;
  assign io.cfg_r_data_o    = cfg_r_v_q ? ram_rdata_q : '0;
  assign io.err_o           = err_q;

endmodule

// File: tb/tb_bp_cce_inst_fetch.sv
// Self-checking bench for bp_cce_inst_fetch: a behavioural RAM/PC model is
// advanced by the architectural fetch rules and compared every cycle.
module tb_bp_cce_inst_fetch;
  localparam int IW = 48;
  localparam int PW = 9;
  localparam int NI = 256;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bp_cce_inst_fetch_if #(.inst_width_p(IW), .pc_width_p(PW)) bus ();

  bp_cce_inst_fetch #(.inst_width_p(IW), .pc_width_p(PW), .num_inst_p(NI)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .io       (bus.slave)
  );

  logic [IW-1:0] mem_m [NI];
  logic          err_m;
  int            exp_pc;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cfg_w_v_i     = 1'b0;
    bus.cfg_r_v_i     = 1'b0;
    bus.cfg_addr_i    = '0;
    bus.cfg_data_i    = '0;
    bus.stall_i       = 1'b0;
    bus.redirect_v_i  = 1'b0;
    bus.redirect_pc_i = '0;
  endtask

  task automatic do_reset();
    idle();
    bus.mode_i = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    err_m = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input logic [IW-1:0] data);
    bus.cfg_w_v_i  = 1'b1;
    bus.cfg_addr_i = PW'(addr);
    bus.cfg_data_i = data;
    tick();
    if (addr < NI) mem_m[addr] = data;
    else err_m = 1'b1;
    bus.cfg_w_v_i = 1'b0;
  endtask

  task automatic run_step(input bit st, input bit rv, input int tgt);
    bus.stall_i       = st;
    bus.redirect_v_i  = rv;
    bus.redirect_pc_i = PW'(tgt);
    tick();
    if (rv) begin
      if (tgt < NI) exp_pc = tgt;
      else begin
        exp_pc = 0;
        err_m  = 1'b1;
      end
    end else if (!st) begin
      exp_pc = (exp_pc + 1) % NI;
    end
    bus.stall_i      = 1'b0;
    bus.redirect_v_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.instruction_v_o !== 1'b0 || bus.instruction_o !== '0 || bus.fetch_pc_o !== '0 ||
        bus.cfg_r_v_o !== 1'b0 || bus.cfg_r_data_o !== '0 || bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b inst=%h pc=%0d rv=%b rd=%h err=%b, want all 0",
               bus.instruction_v_o, bus.instruction_o, bus.fetch_pc_o,
               bus.cfg_r_v_o, bus.cfg_r_data_o, bus.err_o);
    end
  endtask

  task automatic load_all();
    logic [63:0] r;
    for (int i = 0; i < NI; i++) begin
      r = {$urandom, $urandom};
      if (i < 4) r = 64'(i + 1) * 64'h11;
      cfg_write(i, r[IW-1:0]);
    end
  endtask

  task automatic test_load_readback();
    int a;
    bus.cfg_r_v_i  = 1'b1;
    bus.cfg_addr_i = PW'(2);
    tick();
    bus.cfg_r_v_i = 1'b0;
    n_cmp++;
    if (bus.cfg_r_v_o !== 1'b1 || bus.cfg_r_data_o !== 48'h33 || bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL readback_addr2: v=%b data=%h err=%b, want 1/33/0",
               bus.cfg_r_v_o, bus.cfg_r_data_o, bus.err_o);
    end
    tick();
    n_cmp++;
    if (bus.cfg_r_v_o !== 1'b0 || bus.cfg_r_data_o !== '0) begin
      n_fail++;
      $display("FAIL readback_valid_drop: v=%b data=%h, want 0/0", bus.cfg_r_v_o, bus.cfg_r_data_o);
    end
    // back-to-back random reads
    for (int k = 0; k < 8; k++) begin
      a = $urandom_range(NI - 1);
      bus.cfg_r_v_i  = 1'b1;
      bus.cfg_addr_i = PW'(a);
      tick();
      n_cmp++;
      if (bus.cfg_r_v_o !== 1'b1 || bus.cfg_r_data_o !== mem_m[a]) begin
        n_fail++;
        $display("FAIL readback_rand[%0d]: v=%b data=%h, want 1/%h", a,
                 bus.cfg_r_v_o, bus.cfg_r_data_o, mem_m[a]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_boot_sequential();
    bus.mode_i = 1'b1;
    #1;
    n_cmp++;
    if (bus.instruction_v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_load_cycle_v: got %b want 0", bus.instruction_v_o);
    end
    tick();
    n_cmp++;
    if (bus.instruction_v_o !== 1'b0 || bus.instruction_o !== '0) begin
      n_fail++;
      $display("FAIL boot_cycle_v: v=%b inst=%h want 0/0", bus.instruction_v_o, bus.instruction_o);
    end
    tick();
    exp_pc = 0;
    n_cmp++;
    if (bus.instruction_v_o !== 1'b1 || bus.fetch_pc_o !== PW'(0) || bus.instruction_o !== 48'h11) begin
      n_fail++;
      $display("FAIL first_fetch: v=%b pc=%0d inst=%h want 1/0/11",
               bus.instruction_v_o, bus.fetch_pc_o, bus.instruction_o);
    end
    for (int k = 1; k <= 2; k++) begin
      run_step(1'b0, 1'b0, 0);
      n_cmp++;
      if (bus.fetch_pc_o !== PW'(k) || bus.instruction_o !== 48'(k + 1) * 48'h11) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d]: pc=%0d inst=%h want %0d/%h", k,
                 bus.fetch_pc_o, bus.instruction_o, k, 48'(k + 1) * 48'h11);
      end
    end
  endtask

  task automatic test_stall();
    run_step(1'b0, 1'b1, 1);
    for (int k = 0; k < 3; k++) begin
      run_step(1'b1, 1'b0, 0);
      n_cmp++;
      if (bus.fetch_pc_o !== PW'(1) || bus.instruction_o !== 48'h22 || bus.instruction_v_o !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%0d inst=%h want 1/22", k, bus.fetch_pc_o, bus.instruction_o);
      end
    end
    run_step(1'b0, 1'b0, 0);
    n_cmp++;
    if (bus.fetch_pc_o !== PW'(2) || bus.instruction_o !== 48'h33) begin
      n_fail++;
      $display("FAIL stall_release: pc=%0d inst=%h want 2/33", bus.fetch_pc_o, bus.instruction_o);
    end
  endtask

  task automatic test_redirect_over_stall();
    run_step(1'b1, 1'b1, 0);
    n_cmp++;
    if (bus.fetch_pc_o !== PW'(0) || bus.instruction_o !== 48'h11 || bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_over_stall: pc=%0d inst=%h err=%b want 0/11/0",
               bus.fetch_pc_o, bus.instruction_o, bus.err_o);
    end
  endtask

  task automatic test_wrap();
    run_step(1'b0, 1'b1, 254);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.fetch_pc_o !== PW'((254 + k) % NI) || bus.instruction_o !== mem_m[(254 + k) % NI]) begin
        n_fail++;
        $display("FAIL wrap[%0d]: pc=%0d inst=%h want %0d/%h", k, bus.fetch_pc_o,
                 bus.instruction_o, (254 + k) % NI, mem_m[(254 + k) % NI]);
      end
      run_step(1'b0, 1'b0, 0);
    end
  endtask

  task automatic test_random_run();
    bit st, rv;
    int tgt;
    for (int k = 0; k < 300; k++) begin
      st  = ($urandom_range(3) == 0);
      rv  = ($urandom_range(6) == 0);
      tgt = $urandom_range(NI - 1);
      run_step(st, rv, tgt);
      n_cmp++;
      if (bus.fetch_pc_o !== PW'(exp_pc) || bus.instruction_o !== mem_m[exp_pc] ||
          bus.instruction_v_o !== 1'b1 || bus.err_o !== err_m) begin
        n_fail++;
        $display("FAIL random_run[%0d]: pc=%0d inst=%h v=%b err=%b want %0d/%h/1/%b", k,
                 bus.fetch_pc_o, bus.instruction_o, bus.instruction_v_o, bus.err_o,
                 exp_pc, mem_m[exp_pc], err_m);
      end
    end
  endtask

  task automatic test_bad_redirect();
    run_step(1'b1, 1'b1, 'h1FF);
    n_cmp++;
    if (bus.fetch_pc_o !== PW'(0) || bus.instruction_o !== mem_m[0] || bus.err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_redirect: pc=%0d inst=%h err=%b want 0/%h/1",
               bus.fetch_pc_o, bus.instruction_o, bus.err_o, mem_m[0]);
    end
  endtask

  task automatic test_leave_run();
    bus.mode_i = 1'b0;
    tick();
    n_cmp++;
    if (bus.instruction_v_o !== 1'b0 || bus.instruction_o !== '0) begin
      n_fail++;
      $display("FAIL leave_run: v=%b inst=%h want 0/0", bus.instruction_v_o, bus.instruction_o);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [IW-1:0] old5;
    do_reset();
    bus.mode_i = 1'b1;
    tick();
    tick();
    exp_pc = 0;
    run_step(1'b0, 1'b0, 0);
    old5 = mem_m[5];
    bus.cfg_w_v_i  = 1'b1;
    bus.cfg_addr_i = PW'(5);
    bus.cfg_data_i = ~old5;
    run_step(1'b0, 1'b0, 0);
    bus.cfg_w_v_i = 1'b0;
    n_cmp++;
    if (bus.err_o !== 1'b1 || bus.fetch_pc_o !== PW'(exp_pc) || bus.instruction_o !== mem_m[exp_pc]) begin
      n_fail++;
      $display("FAIL run_cfg_write: err=%b pc=%0d inst=%h want 1/%0d/%h",
               bus.err_o, bus.fetch_pc_o, bus.instruction_o, exp_pc, mem_m[exp_pc]);
    end
    run_step(1'b0, 1'b1, 3);
    reset_n = 1'b0;
    bus.mode_i = 1'b0;
    tick();
    n_cmp++;
    if (bus.instruction_v_o !== 1'b0 || bus.instruction_o !== '0 || bus.fetch_pc_o !== '0 ||
        bus.cfg_r_v_o !== 1'b0 || bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: v=%b inst=%h pc=%0d rv=%b err=%b want all 0",
               bus.instruction_v_o, bus.instruction_o, bus.fetch_pc_o, bus.cfg_r_v_o, bus.err_o);
    end
    reset_n = 1'b1;
    err_m = 1'b0;
    foreach (mem_m[i]) begin
      if (i == 5 || i == 0 || i == 200) begin
        bus.cfg_r_v_i  = 1'b1;
        bus.cfg_addr_i = PW'(i);
        tick();
        n_cmp++;
        if (bus.cfg_r_v_o !== 1'b1 || bus.cfg_r_data_o !== mem_m[i] || bus.err_o !== 1'b0) begin
          n_fail++;
          $display("FAIL ram_retained[%0d]: v=%b data=%h err=%b want 1/%h/0", i,
                   bus.cfg_r_v_o, bus.cfg_r_data_o, bus.err_o, mem_m[i]);
        end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_load_errors();
    logic [IW-1:0] nv;
    do_reset();
    nv = {16'hA5A5, $urandom};
    bus.cfg_r_v_i = 1'b1;
    cfg_write(7, nv);
    bus.cfg_r_v_i = 1'b0;
    n_cmp++;
    if (bus.cfg_r_v_o !== 1'b0 || bus.err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_rd_collision: rv=%b err=%b want 0/1", bus.cfg_r_v_o, bus.err_o);
    end
    bus.cfg_r_v_i  = 1'b1;
    bus.cfg_addr_i = PW'(7);
    tick();
    bus.cfg_r_v_i = 1'b0;
    n_cmp++;
    if (bus.cfg_r_data_o !== nv) begin
      n_fail++;
      $display("FAIL collision_write_done: data=%h want %h", bus.cfg_r_data_o, nv);
    end
    do_reset();
    cfg_write(300, ~mem_m[44]);
    n_cmp++;
    if (bus.err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_write_err: err=%b want 1", bus.err_o);
    end
    bus.cfg_r_v_i  = 1'b1;
    bus.cfg_addr_i = PW'(300);
    tick();
    n_cmp++;
    if (bus.cfg_r_v_o !== 1'b0 || bus.cfg_r_data_o !== '0) begin
      n_fail++;
      $display("FAIL oob_read_dropped: v=%b data=%h want 0/0", bus.cfg_r_v_o, bus.cfg_r_data_o);
    end
    bus.cfg_addr_i = PW'(44);
    tick();
    bus.cfg_r_v_i = 1'b0;
    n_cmp++;
    if (bus.cfg_r_v_o !== 1'b1 || bus.cfg_r_data_o !== mem_m[44]) begin
      n_fail++;
      $display("FAIL oob_no_alias: v=%b data=%h want 1/%h", bus.cfg_r_v_o, bus.cfg_r_data_o, mem_m[44]);
    end
    tick();
  endtask

  initial begin
    idle();
    bus.mode_i = 1'b0;
    reset_n = 1'b0;
    err_m = 1'b0;
    exp_pc = 0;
    test_reset();
    load_all();
    test_load_readback();
    test_boot_sequential();
    test_stall();
    test_redirect_over_stall();
    test_wrap();
    test_random_run();
    test_bad_redirect();
    test_leave_run();
    test_reset_mid_run();
    test_load_errors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
